// File: rtl/uart_byte_controller_if.sv
// Byte-level handshake between the stdio call blocks and the UART engine.
// Serial pins stay plain ports on the engine itself.
interface uart_byte_controller_if;
    logic [7:0] UART_BYTE_OUT;
    logic       UART_START_SEND;
    logic       UART_START_RECEIVE;
    logic [7:0] UART_BYTE_IN;
    logic [1:0] UART_RESPONSE;

    modport master (
        output UART_BYTE_OUT, UART_START_SEND, UART_START_RECEIVE,
        input  UART_BYTE_IN, UART_RESPONSE
    );

    modport slave (
        input  UART_BYTE_OUT, UART_START_SEND, UART_START_RECEIVE,
        output UART_BYTE_IN, UART_RESPONSE
    );
endinterface

// File: rtl/uart_byte_controller.sv
// 8N1 UART byte engine: independent TX and RX FSMs, with a 1-deep pending
// slot and a held RX-valid response for the get-char side.
module uart_byte_controller #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HOLD_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_byte_controller_if.slave bus,
    input  logic                  UART_RXD,
    output logic                  UART_TXD
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_MID   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    // ---------------- TX ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;

    tx_state_t     tx_state, tx_state_d;
    logic [CW-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]    tx_idx, tx_idx_d;
    logic [7:0]    tx_shift, tx_shift_d;
    logic          txd_d;
    logic          tx_done;
    logic          tx_last;

    assign tx_last = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            UART_TXD <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_idx   <= tx_idx_d;
            tx_shift <= tx_shift_d;
            UART_TXD <= txd_d;
            tx_done  <= (tx_state == TX_DONE);
        end
    end

    // Pin level follows the current state one cycle later, so the line
    // falls on the edge after the request is sampled.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_idx_d   = tx_idx;
        tx_shift_d = tx_shift;
        txd_d      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (bus.UART_START_SEND) begin
                    tx_shift_d = bus.UART_BYTE_OUT;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                txd_d = 1'b0;
                if (tx_last) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt + CNT_ONE;
                end
            end
            TX_DATA: begin
                txd_d = tx_shift[tx_idx];
                if (tx_last) begin
                    tx_cnt_d = '0;
                    if (tx_idx == 3'd7) tx_state_d = TX_STOP;
                    else                tx_idx_d   = tx_idx + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_last) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DONE;
                end else begin
                    tx_cnt_d = tx_cnt + CNT_ONE;
                end
            end
            TX_DONE: tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- RX ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic          rx_meta, rx_sync;
    rx_state_t     rx_state, rx_state_d;
    logic [CW-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]    rx_idx, rx_idx_d;
    logic [7:0]    rx_shift, rx_shift_d;
    logic          rx_good_d, rx_good_q;
    logic [7:0]    rx_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_shift  <= '0;
            rx_good_q <= 1'b0;
            rx_data_q <= '0;
        end else begin
            rx_meta   <= UART_RXD;
            rx_sync   <= rx_meta;
            rx_state  <= rx_state_d;
            rx_cnt    <= rx_cnt_d;
            rx_idx    <= rx_idx_d;
            rx_shift  <= rx_shift_d;
            rx_good_q <= rx_good_d;
            if (rx_good_d) rx_data_q <= rx_shift;
        end
    end

    // After the mid-start check the counter wraps every bit period, so all
    // later samples land at the same offset into their bit.
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_idx_d   = rx_idx;
        rx_shift_d = rx_shift;
        rx_good_d  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == BIT_MID) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync, rx_shift[7:1]};
                    if (rx_idx == 3'd7) rx_state_d = RX_STOP;
                    else                rx_idx_d   = rx_idx + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_good_d  = rx_sync;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt + CNT_ONE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- delivery ----------------
    logic          armed;
    logic          pend_vld;
    logic [7:0]    pend_data;
    logic [HW-1:0] hold_cnt;
    logic          rx_valid;
    logic [7:0]    byte_in;
    logic          hold_idle;
    logic          deliver_pend, deliver_new;

    assign hold_idle    = (hold_cnt == '0);
    // The pending byte always goes first; a byte landing alongside it is parked.
    assign deliver_pend = armed & pend_vld & hold_idle;
    assign deliver_new  = armed & rx_good_q & hold_idle & ~pend_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed     <= 1'b0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            hold_cnt  <= '0;
            rx_valid  <= 1'b0;
            byte_in   <= '0;
        end else begin
            if (deliver_pend || deliver_new) begin
                byte_in  <= deliver_pend ? pend_data : rx_data_q;
                hold_cnt <= HOLD_LOAD;
                rx_valid <= 1'b1;
                armed    <= 1'b0;
            end else begin
                if (!hold_idle) hold_cnt <= hold_cnt - HOLD_ONE;
                rx_valid <= (hold_cnt > HOLD_ONE);
                if (bus.UART_START_RECEIVE && !rx_valid) armed <= 1'b1;
            end

            if (rx_good_q && !deliver_new) begin
                pend_data <= rx_data_q;
                pend_vld  <= 1'b1;
            end else if (deliver_pend) begin
                pend_vld <= 1'b0;
            end
        end
    end

    assign bus.UART_BYTE_IN  = byte_in;
    assign bus.UART_RESPONSE = {rx_valid, tx_done};
endmodule

// File: tb/tb_uart_byte_controller.sv
// Directed bench for uart_byte_controller at CLKS_PER_BIT=8, HOLD_CYCLES=4.
module tb_uart_byte_controller;
    logic clk;
    logic reset;
    logic rxd;
    logic txd;
    int   total;
    int   bad;
    int   tcur;
    int   send_hold;

    uart_byte_controller_if bif ();

    uart_byte_controller #(.CLKS_PER_BIT(8), .HOLD_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bif),
        .UART_RXD (rxd),
        .UART_TXD (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance to relative cycle 'to' after the send edge, releasing the request
    // once it has been seen on send_hold edges.
    task automatic adv(input int to);
        while (tcur < to) begin
            @(posedge clk);
            #1;
            tcur++;
            if (tcur >= send_hold - 1) bif.UART_START_SEND = 1'b0;
        end
    endtask

    // Returns #1 after the edge that raises the TX-done pulse.
    task automatic tx_frame(input logic [7:0] b, input int hold, input string tag);
        logic [9:0] got;
        logic [9:0] want;
        want = {1'b1, b, 1'b0};
        got  = '0;
        bif.UART_BYTE_OUT   = b;
        bif.UART_START_SEND = 1'b1;
        send_hold = hold;
        @(posedge clk);
        #1;
        tcur = 0;
        if (hold <= 1) bif.UART_START_SEND = 1'b0;
        chk({tag, "_done_lo0"}, 32'(bif.UART_RESPONSE[0]), 0);
        chk({tag, "_idle"}, 32'(txd), 1);
        adv(1);
        chk({tag, "_fall"}, 32'(txd), 0);
        for (int k = 0; k < 10; k++) begin
            adv(5 + 8 * k);
            got[k] = txd;
        end
        chk({tag, "_bits"}, 32'(got), 32'(want));
        adv(80);
        chk({tag, "_done_early"}, 32'(bif.UART_RESPONSE[0]), 0);
        adv(81);
        chk({tag, "_done"}, 32'(bif.UART_RESPONSE[0]), 1);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = f[k];
            repeat (8) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    task automatic arm();
        bif.UART_START_RECEIVE = 1'b1;
        @(posedge clk);
        #1;
        bif.UART_START_RECEIVE = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tcur  = 0;
        send_hold = 1;
        reset = 1'b0;
        rxd   = 1'b1;
        bif.UART_BYTE_OUT      = '0;
        bif.UART_START_SEND    = 1'b0;
        bif.UART_START_RECEIVE = 1'b0;

        #12;
        chk("rst_txd", 32'(txd), 1);
        chk("rst_resp", 32'(bif.UART_RESPONSE), 0);
        chk("rst_byte", 32'(bif.UART_BYTE_IN), 0);
        @(negedge clk);
        reset = 1'b1;
        tick(2);

        // TX basic and back-to-back
        tx_frame(8'hA5, 1, "txa5");
        tick(1);
        chk("txa5_done_lo", 32'(bif.UART_RESPONSE[0]), 0);
        tick(2);
        tx_frame(8'hC3, 3, "b2b1");
        tx_frame(8'h3C, 1, "b2b2");
        tick(1);
        chk("b2b2_done_lo", 32'(bif.UART_RESPONSE[0]), 0);
        tick(2);

        // RX armed; re-arm during hold ignored
        arm();
        rx_byte(8'h5A, 1'b1);
        tick(1);
        chk("rx5a_vld", 32'(bif.UART_RESPONSE[1]), 1);
        chk("rx5a_byte", 32'(bif.UART_BYTE_IN), 32'h5A);
        bif.UART_START_RECEIVE = 1'b1;
        tick(1);
        bif.UART_START_RECEIVE = 1'b0;
        tick(2);
        chk("rx5a_hold", 32'(bif.UART_RESPONSE[1]), 1);
        tick(1);
        chk("rx5a_drop", 32'(bif.UART_RESPONSE[1]), 0);

        // Unarmed bytes; newest pending wins
        rx_byte(8'h11, 1'b1);
        tick(1);
        chk("rx11_noarm", 32'(bif.UART_RESPONSE[1]), 0);
        rx_byte(8'h22, 1'b1);
        tick(1);
        chk("rx22_noarm", 32'(bif.UART_RESPONSE[1]), 0);
        arm();
        chk("pend_arm_edge", 32'(bif.UART_RESPONSE[1]), 0);
        tick(1);
        chk("pend_vld", 32'(bif.UART_RESPONSE[1]), 1);
        chk("pend_byte", 32'(bif.UART_BYTE_IN), 32'h22);
        tick(4);
        chk("pend_drop", 32'(bif.UART_RESPONSE[1]), 0);

        // Glitch and framing error leave nothing behind
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(20);
        rx_byte(8'h55, 1'b0);
        tick(20);
        arm();
        tick(1);
        chk("err_nopend", 32'(bif.UART_RESPONSE[1]), 0);
        chk("err_keep", 32'(bif.UART_BYTE_IN), 32'h22);
        rx_byte(8'h77, 1'b1);
        tick(1);
        chk("rx77_vld", 32'(bif.UART_RESPONSE[1]), 1);
        chk("rx77_byte", 32'(bif.UART_BYTE_IN), 32'h77);
        tick(4);

        // Reset in the middle of a TX and an RX frame
        rxd = 1'b0;
        bif.UART_BYTE_OUT   = 8'hFF;
        bif.UART_START_SEND = 1'b1;
        tick(1);
        bif.UART_START_SEND = 1'b0;
        tick(3);
        chk("mid_txd_start", 32'(txd), 0);
        tick(37);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_txd", 32'(txd), 1);
        chk("mid_rst_resp", 32'(bif.UART_RESPONSE), 0);
        chk("mid_rst_byte", 32'(bif.UART_BYTE_IN), 0);
        rxd = 1'b1;
        tick(2);
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        tx_frame(8'h01, 1, "txpost");
        tick(1);
        arm();
        rx_byte(8'h02, 1'b1);
        tick(1);
        chk("rxpost_vld", 32'(bif.UART_RESPONSE[1]), 1);
        chk("rxpost_byte", 32'(bif.UART_BYTE_IN), 32'h02);
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
